armish_mc_datapath_p: RTL and testbench
=======================================

Name: armish_mc_datapath_p

Overview:
Parametrised multicycle datapath for the ARMish core, successor to the fixed 32-bit/16-register datapath. Adds a memory request/acknowledge handshake with a WAIT state and architectural freeze during stalls, configurable data width, register count and reset PC, full NZCV flag storage and a 4-bit condition evaluator. The external control FSM drives it and stalls on mem_busy.

Parameters:
DATA_W, 32, datapath/register/memory word width (>=32)
NREG, 16, register count (8 or 16); link register is NREG-1
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
pc_write  in  1  PC load strobe
jump  in  1  PC load strobe (OR'd with pc_write)
i_or_d  in  1  memory address source: 0 = PC, 1 = ALUOut
rd1_sel  in  1  read port 1 index: 0 = IR[19:16], 1 = IR[15:12]
reg_dst  in  1  write index: 0 = NREG-1, 1 = IR[15:12]
ir_write  in  1  capture the pending read into IR
mem_to_reg  in  2  write data: 0 = PC, 1 = ALUOut, 2 = MDR
reg_write  in  1  register file write enable
alu_src_a  in  2  0 = PC, 1 = sext(IR[25:0]), 2 = A
alu_src_b  in  2  0 = B, 1 = 1, 2 = sext(IR[11:0]), 3 = ALUOut
alu_op  in  3  0 ADD, 1 SUB (A-B), 2 AND, 3 ORR, 4 EOR, 5 MOV B, 6 MVN B, 7 RSB (B-A)
pc_src  in  1  PC input: 0 = ALU result, 1 = ALUOut
ld_cv  in  1  load C and V
ld_zn  in  1  load Z and N
mem_rd  in  1  start read
mem_wr  in  1  start write
mem_ack  in  1  memory completion
mem_rdata  in  DATA_W  read data
mem_req  out  1  request valid
mem_we  out  1  request is a write
mem_addr  out  DATA_W  registered request address
mem_wdata  out  DATA_W  registered write data (register A)
mem_busy  out  1  transaction outstanding
instruction  out  DATA_W  IR contents
lt, gt, eq  out  1  N^V; !Z&(N==V); Z
cond_pass  out  1  evaluation of IR[31:28]

Behaviour:
- Reset (async): PC = RESET_PC; IR, MDR, A, B, ALUOut, NZCV, all registers and mem_* outputs = 0; state IDLE; mem_busy = 0.
- Handshake FSM, IDLE/WAIT:
  - IDLE with mem_rd|mem_wr: next edge registers mem_addr (i_or_d mux), mem_wdata = A, mem_we = mem_wr (write wins if both asserted) and the ir_write flag; mem_req = 1; go to WAIT.
  - WAIT: outputs stay stable; mem_rd and mem_wr are ignored.
  - WAIT with mem_ack: for a read, MDR <= mem_rdata, plus IR if the ir_write flag was captured. mem_req = 0; go to IDLE.
  - mem_ack in IDLE is ignored.
  - Minimum read latency: request issued 1 cycle after mem_rd; data in MDR/IR at the edge of mem_ack.
- mem_busy = (state == WAIT). While busy, PC, register file, NZCV, A, B and ALUOut are frozen and all strobes are ignored.
- When not busy: A, B and ALUOut load every cycle. The register file writes on reg_write. PC loads on pc_write|jump.
- Register file: async read, sync write. Register indices use the low log2(NREG) bits of the fields. Writes to the index being read show the old value until the next edge.
- Flags:
  - ADD C = carry-out. SUB/RSB C = no-borrow.
  - V = signed overflow, for ADD/SUB/RSB only; logic ops give C = 0, V = 0.
  - Z = (result == 0). N = result[DATA_W-1].
- cond_pass codes: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI (C&!Z), 9 LS, A GE, B LT, C GT, D LE, E AL, F = 0.
- All arithmetic is modulo 2^DATA_W. Sign extension goes to DATA_W.

Decomposition:
- Package armish_pkg: alu_op encodings, cond codes, mux select encodings, fsm state type.
- Sub-module armish_regfile (NREG x DATA_W, 2 read ports, 1 write port).
- ALU and condition evaluator stay inline.

Test Plan:
- Fetch, 0 wait: mem_rd=1, i_or_d=0, ir_write=1 at PC=0; mem_ack in the first WAIT cycle with rdata 0xE0812003 -> mem_req high for 1 cycle; IR = 0xE0812003; mem_busy 1 cycle.
- Fetch, 3 waits with pc_write held at 1 -> PC unchanged until busy clears; mem_addr stable for all 3 cycles.
- ADD overflow: A = 0x7FFFFFFF, B = 1, ld_cv = ld_zn = 1 -> ALUOut = 0x80000000; N=1, V=1, C=0, Z=0; lt=0, gt=1, cond_pass(GE)=1.
- SUB equal: 5 - 5 -> Z=1, C=1; eq=1; cond_pass(EQ)=1, cond_pass(NE)=0, cond_pass(HI)=0.
- Store: mem_wr=1, A = 0xDEADBEEF, i_or_d=1, ALUOut = 0x40 -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF; MDR unchanged after ack.
- Reset asserted in WAIT: mem_req and mem_busy drop immediately; PC = RESET_PC; a stale mem_ack after reset changes nothing.

Source files
------------

// File: rtl/armish_pkg.sv
`default_nettype none
// ============================================================================
// armish_pkg : shared encodings for the ARMish multicycle datapath
// Revision   : 1.0
// ============================================================================
package armish_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_EOR = 3'd4,
    ALU_MOV = 3'd5,
    ALU_MVN = 3'd6,
    ALU_RSB = 3'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_IMM26  = 2'd1;
  localparam logic [1:0] SRCA_A      = 2'd2;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_ONE    = 2'd1;
  localparam logic [1:0] SRCB_IMM12  = 2'd2;
  localparam logic [1:0] SRCB_ALUOUT = 2'd3;

  localparam logic [1:0] WB_PC       = 2'd0;
  localparam logic [1:0] WB_ALUOUT   = 2'd1;
  localparam logic [1:0] WB_MDR      = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/armish_regfile.sv
`default_nettype none
// ============================================================================
// armish_regfile : NREG x DATA_W register file, 2 async read / 1 sync write
// Revision       : 1.0
// ============================================================================
module armish_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [IDX_W-1:0]  ra1,
  input  logic [IDX_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[wa] <= wd;
    end
  end

  assign rd1 = regs_q[ra1];
  assign rd2 = regs_q[ra2];

endmodule
`default_nettype wire

// File: rtl/armish_mc_datapath_p.sv
`default_nettype none
// ============================================================================
// armish_mc_datapath_p : parametrised multicycle datapath, mem handshake + NZCV
// Revision             : 1.0
// ============================================================================
module armish_mc_datapath_p
  import armish_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NREG     = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              jump,
  input  logic              i_or_d,
  input  logic              rd1_sel,
  input  logic              reg_dst,
  input  logic              ir_write,
  input  logic [1:0]        mem_to_reg,
  input  logic              reg_write,
  input  logic [1:0]        alu_src_a,
  input  logic [1:0]        alu_src_b,
  input  logic [2:0]        alu_op,
  input  logic              pc_src,
  input  logic              ld_cv,
  input  logic              ld_zn,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_busy,
  output logic [DATA_W-1:0] instruction,
  output logic              lt,
  output logic              gt,
  output logic              eq,
  output logic              cond_pass
);

  localparam int IDX_W = $clog2(NREG);
  localparam int MSB   = DATA_W - 1;

  logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic              n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

  mem_state_e        state_q;
  logic              mem_req_q, mem_we_q, mem_irw_q;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic              busy;

  logic              rf_we;
  logic [IDX_W-1:0]  rf_wa, rf_ra1, rf_ra2;
  logic [DATA_W-1:0] rf_wd, rf_rd1, rf_rd2;

  logic [DATA_W-1:0] src_a, src_b, alu_res;
  logic [DATA_W:0]   wide;
  logic              alu_c, alu_v;

  logic              unused_ir;
  assign unused_ir = ^ir_q[27:26];

  assign busy = (state_q == ST_WAIT);

  armish_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk (clk),
    .rst (rst),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .ra1 (rf_ra1),
    .ra2 (rf_ra2),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  always_comb begin
    rf_ra1 = rd1_sel ? ir_q[12 +: IDX_W] : ir_q[16 +: IDX_W];
    rf_ra2 = ir_q[0 +: IDX_W];
    rf_wa  = reg_dst ? ir_q[12 +: IDX_W] : IDX_W'(NREG - 1);
    rf_we  = reg_write & ~busy;
    case (mem_to_reg)
      WB_PC:   rf_wd = pc_q;
      WB_MDR:  rf_wd = mdr_q;
      default: rf_wd = alu_out_q;
    endcase
  end

  always_comb begin
    case (alu_src_a)
      SRCA_PC:    src_a = pc_q;
      SRCA_IMM26: src_a = {{(DATA_W-26){ir_q[25]}}, ir_q[25:0]};
      default:    src_a = a_q;
    endcase
    case (alu_src_b)
      SRCB_B:     src_b = b_q;
      SRCB_ONE:   src_b = DATA_W'(1);
      SRCB_IMM12: src_b = {{(DATA_W-12){ir_q[11]}}, ir_q[11:0]};
      default:    src_b = alu_out_q;
    endcase
  end

  // Subtraction is done as a + ~b + 1 so the carry-out is directly the no-borrow flag.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin
        wide    = {1'b0, src_a} + {1'b0, src_b};
        alu_res = wide[MSB:0];
        alu_c   = wide[DATA_W];
        alu_v   = (src_a[MSB] == src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      ALU_SUB: begin
        wide    = {1'b0, src_a} + {1'b0, ~src_b} + (DATA_W+1)'(1);
        alu_res = wide[MSB:0];
        alu_c   = wide[DATA_W];
        alu_v   = (src_a[MSB] != src_b[MSB]) && (alu_res[MSB] != src_a[MSB]);
      end
      ALU_RSB: begin
        wide    = {1'b0, src_b} + {1'b0, ~src_a} + (DATA_W+1)'(1);
        alu_res = wide[MSB:0];
        alu_c   = wide[DATA_W];
        alu_v   = (src_b[MSB] != src_a[MSB]) && (alu_res[MSB] != src_b[MSB]);
      end
      ALU_AND: alu_res = src_a & src_b;
      ALU_ORR: alu_res = src_a | src_b;
      ALU_EOR: alu_res = src_a ^ src_b;
      ALU_MOV: alu_res = src_b;
      default: alu_res = ~src_b;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    n_d       = n_q;
    z_d       = z_q;
    c_d       = c_q;
    v_d       = v_q;
    if (!busy) begin
      a_d       = rf_rd1;
      b_d       = rf_rd2;
      alu_out_d = alu_res;
      if (pc_write | jump) pc_d = pc_src ? alu_out_q : alu_res;
      if (ld_cv) begin
        c_d = alu_c;
        v_d = alu_v;
      end
      if (ld_zn) begin
        z_d = (alu_res == '0);
        n_d = alu_res[MSB];
      end
    end else if (mem_ack && !mem_we_q) begin
      mdr_d = mem_rdata;
      if (mem_irw_q) ir_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      n_q       <= n_d;
      z_q       <= z_d;
      c_q       <= c_d;
      v_q       <= v_d;
    end
  end

  // Request fields are captured once on entry to WAIT and held until the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_irw_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_rd | mem_wr) begin
            state_q     <= ST_WAIT;
            mem_req_q   <= 1'b1;
            mem_we_q    <= mem_wr;
            mem_irw_q   <= ir_write;
            mem_addr_q  <= i_or_d ? alu_out_q : pc_q;
            mem_wdata_q <= a_q;
          end
        end
        default: begin
          if (mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    case (cond_e'(ir_q[31:28]))
      COND_EQ: cond_pass = z_q;
      COND_NE: cond_pass = ~z_q;
      COND_CS: cond_pass = c_q;
      COND_CC: cond_pass = ~c_q;
      COND_MI: cond_pass = n_q;
      COND_PL: cond_pass = ~n_q;
      COND_VS: cond_pass = v_q;
      COND_VC: cond_pass = ~v_q;
      COND_HI: cond_pass = c_q & ~z_q;
      COND_LS: cond_pass = ~c_q | z_q;
      COND_GE: cond_pass = (n_q == v_q);
      COND_LT: cond_pass = (n_q != v_q);
      COND_GT: cond_pass = ~z_q & (n_q == v_q);
      COND_LE: cond_pass = z_q | (n_q != v_q);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign lt          = n_q ^ v_q;
  assign gt          = ~z_q & (n_q ~^ v_q);
  assign eq          = z_q;
  assign instruction = ir_q;
  assign mem_busy    = busy;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_armish_mc_datapath_p.sv
`default_nettype none
// ============================================================================
// tb_armish_mc_datapath_p : scoreboard bench with a transaction-level model
// Revision                : 1.0
// ============================================================================
module tb_armish_mc_datapath_p;

  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] RPC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, jump, i_or_d, rd1_sel, reg_dst, ir_write, reg_write;
  logic        pc_src, ld_cv, ld_zn, mem_rd, mem_wr, mem_ack;
  logic [1:0]  mem_to_reg, alu_src_a, alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we, mem_busy, lt, gt, eq, cond_pass;
  logic [31:0] mem_addr, mem_wdata, instruction;

  always #5 clk = ~clk;

  armish_mc_datapath_p #(.DATA_W(DW), .NREG(NR), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .jump(jump), .i_or_d(i_or_d),
    .rd1_sel(rd1_sel), .reg_dst(reg_dst), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .ld_cv(ld_cv),
    .ld_zn(ld_zn), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .instruction(instruction), .lt(lt), .gt(gt), .eq(eq), .cond_pass(cond_pass)
  );

  typedef struct packed {
    logic       pc_write, jump, i_or_d, rd1_sel, reg_dst, ir_write;
    logic       reg_write, pc_src, ld_cv, ld_zn, mem_rd, mem_wr;
    logic [1:0] mem_to_reg, alu_src_a, alu_src_b;
    logic [2:0] alu_op;
  } ctl_t;

  typedef struct {
    logic [31:0] addr, wdata, ir_after;
    logic        we;
    int          cycles;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Architectural model state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_alu;
  logic [31:0] m_reg [NR];
  bit          m_n, m_z, m_c, m_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pc = RPC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_alu = 0;
    m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    for (int i = 0; i < NR; i++) m_reg[i] = 0;
  endfunction

  function automatic bit cond_model(input logic [3:0] code);
    case (code)
      4'h0: return m_z;
      4'h1: return !m_z;
      4'h2: return m_c;
      4'h3: return !m_c;
      4'h4: return m_n;
      4'h5: return !m_n;
      4'h6: return m_v;
      4'h7: return !m_v;
      4'h8: return m_c && !m_z;
      4'h9: return !m_c || m_z;
      4'hA: return m_n == m_v;
      4'hB: return m_n != m_v;
      4'hC: return !m_z && (m_n == m_v);
      4'hD: return m_z || (m_n != m_v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One unstalled clock edge, computed with 64-bit integer arithmetic.
  function automatic void model_edge(input ctl_t c);
    logic [31:0] sa, sb, r, wb, na, nb;
    longint unsigned ua, ub;
    longint sxa, sxb, full, lim;
    bit cy, ov, arith;
    lim = 64'sd2147483647;
    sa = (c.alu_src_a == 2'd0) ? m_pc :
         (c.alu_src_a == 2'd1) ? {{6{m_ir[25]}}, m_ir[25:0]} : m_a;
    case (c.alu_src_b)
      2'd0:    sb = m_b;
      2'd1:    sb = 32'd1;
      2'd2:    sb = {{20{m_ir[11]}}, m_ir[11:0]};
      default: sb = m_alu;
    endcase
    ua = 64'(sa); ub = 64'(sb);
    sxa = longint'($signed(sa)); sxb = longint'($signed(sb));
    cy = 0; ov = 0; full = 0; arith = 0;
    case (c.alu_op)
      3'd0: begin r = sa + sb; cy = (ua + ub) > 64'hFFFF_FFFF; full = sxa + sxb; arith = 1; end
      3'd1: begin r = sa - sb; cy = ua >= ub; full = sxa - sxb; arith = 1; end
      3'd2: r = sa & sb;
      3'd3: r = sa | sb;
      3'd4: r = sa ^ sb;
      3'd5: r = sb;
      3'd6: r = ~sb;
      default: begin r = sb - sa; cy = ub >= ua; full = sxb - sxa; arith = 1; end
    endcase
    if (arith) ov = (full > lim) || (full < -lim - 1);
    case (c.mem_to_reg)
      2'd0:    wb = m_pc;
      2'd2:    wb = m_mdr;
      default: wb = m_alu;
    endcase
    na = m_reg[c.rd1_sel ? m_ir[15:12] : m_ir[19:16]];
    nb = m_reg[m_ir[3:0]];
    if (c.reg_write) m_reg[c.reg_dst ? m_ir[15:12] : 4'd15] = wb;
    if (c.pc_write || c.jump) m_pc = c.pc_src ? m_alu : r;
    if (c.ld_cv) begin m_c = cy; m_v = ov; end
    if (c.ld_zn) begin m_z = (r == 0); m_n = r[31]; end
    m_a = na; m_b = nb; m_alu = r;
  endfunction

  task automatic drive(input ctl_t c);
    pc_write = c.pc_write; jump = c.jump; i_or_d = c.i_or_d; rd1_sel = c.rd1_sel;
    reg_dst = c.reg_dst; ir_write = c.ir_write; reg_write = c.reg_write;
    pc_src = c.pc_src; ld_cv = c.ld_cv; ld_zn = c.ld_zn; mem_rd = c.mem_rd;
    mem_wr = c.mem_wr; mem_to_reg = c.mem_to_reg; alu_src_a = c.alu_src_a;
    alu_src_b = c.alu_src_b; alu_op = c.alu_op;
  endtask

  task automatic check_flags(input string name);
    logic [3:0] e;
    e = {m_n ^ m_v, !m_z && (m_n == m_v), m_z, cond_model(m_ir[31:28])};
    chk(name, {28'd0, lt, gt, eq, cond_pass}, {28'd0, e});
  endtask

  function automatic ctl_t rand_ctl();
    ctl_t c;
    c = ctl_t'($urandom);
    c.mem_to_reg = 2'($urandom_range(0, 2));
    c.alu_src_a  = 2'($urandom_range(0, 2));
    c.mem_rd = 0; c.mem_wr = 0;
    return c;
  endfunction

  // Idle-state cycle; a random mem_ack is applied and must be ignored.
  task automatic cyc(input ctl_t c);
    c.mem_rd = 0; c.mem_wr = 0;
    drive(c);
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk);
    model_edge(c);
    @(negedge clk);
    mem_ack = 0;
    check_flags("flags_idle");
  endtask

  task automatic mem_txn(input ctl_t c, input logic [31:0] rdata, input int waits);
    txn_t t;
    ctl_t j;
    t.addr     = c.i_or_d ? m_alu : m_pc;
    t.we       = c.mem_wr;
    t.wdata    = m_a;
    t.cycles   = waits + 1;
    t.ir_after = (!c.mem_wr && c.ir_write) ? rdata : m_ir;
    exp_q.push_back(t);
    drive(c);
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk);
    model_edge(c);
    @(negedge clk);
    check_flags("flags_issue");
    for (int k = 0; k <= waits; k++) begin
      j = ctl_t'($urandom);
      j.pc_write = 1;
      drive(j);
      mem_ack = (k == waits);
      mem_rdata = (k == waits) ? rdata : $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    if (!t.we) begin
      m_mdr = rdata;
      if (c.ir_write) m_ir = rdata;
    end
    mem_ack = 0;
    check_flags("flags_frozen");
  endtask

  task automatic set_ir(input logic [31:0] instr);
    ctl_t c;
    c = '0; c.mem_rd = 1; c.ir_write = 1;
    mem_txn(c, instr, 0);
  endtask

  task automatic load_reg(input logic [3:0] r, input logic [31:0] val);
    ctl_t c;
    set_ir(32'hE000_0000 | (32'(r) << 12));
    c = '0; c.mem_rd = 1;
    mem_txn(c, val, int'($urandom_range(0, 2)));
    c = '0; c.reg_write = 1; c.reg_dst = 1; c.mem_to_reg = 2'd2;
    cyc(c);
  endtask

  // Monitor: pops an expected transaction when a request appears and checks it until completion.
  txn_t cur;
  bit   have_cur = 0;
  bit   prev_busy = 0;
  int   busy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 0;
      have_cur  = 0;
    end else begin
      if (mem_busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_request: got addr 0x%0h, expected no request", mem_addr);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          busy_cnt = 0;
        end
      end
      if (mem_busy && have_cur) begin
        busy_cnt++;
        chk("req_we", {30'd0, mem_req, mem_we}, {30'd0, 1'b1, cur.we});
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (!mem_busy && prev_busy && have_cur) begin
        chk("busy_cycles", 32'(busy_cnt), 32'(cur.cycles));
        chk("ir_after_txn", instruction, cur.ir_after);
        chk("req_low_after", {31'd0, mem_req}, 32'd0);
        have_cur = 0;
      end
      prev_busy = mem_busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    ctl_t c;
    txn_t t;
    int   k;
    rst = 1;
    drive('0);
    mem_ack = 0; mem_rdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_instr", instruction, 32'd0);
    chk("reset_mem_ctl", {29'd0, mem_req, mem_we, mem_busy}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_flags", {28'd0, lt, gt, eq, cond_pass}, 32'b0100);
    rst = 0;

    // Zero-wait fetch at the reset PC
    set_ir(32'hE081_2003);
    chk("fetch_ir", instruction, 32'hE081_2003);

    // Three-wait fetch with pc_write held; PC advances only on the issue edge
    c = '0; c.mem_rd = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'd1;
    mem_txn(c, 32'hE000_0000, 3);
    c = '0; c.mem_rd = 1;
    mem_txn(c, 32'h1234_5678, 0);

    // ADD overflow: 0x7FFFFFFF + 1
    load_reg(4'd1, 32'h7FFF_FFFF);
    load_reg(4'd2, 32'h0000_0001);
    set_ir(32'hA001_0002);
    cyc('0);
    c = '0; c.alu_src_a = 2'd2; c.alu_op = 3'd0; c.ld_cv = 1; c.ld_zn = 1;
    cyc(c);
    chk("add_ovf_flags", {28'd0, lt, gt, eq, cond_pass}, 32'b0101);
    c = '0; c.mem_wr = 1; c.i_or_d = 1;
    t.addr = 32'h8000_0000;
    chk("add_ovf_model", m_alu, t.addr);
    mem_txn(c, 32'h0, 1);

    // SUB equal: 5 - 5, then re-evaluate under other condition codes
    load_reg(4'd3, 32'd5);
    load_reg(4'd4, 32'd5);
    set_ir(32'h0003_0004);
    cyc('0);
    c = '0; c.alu_src_a = 2'd2; c.alu_op = 3'd1; c.ld_cv = 1; c.ld_zn = 1;
    cyc(c);
    chk("sub_eq_flags", {28'd0, lt, gt, eq, cond_pass}, 32'b0011);
    set_ir(32'h1003_0004);
    chk("sub_ne_flags", {28'd0, lt, gt, eq, cond_pass}, 32'b0010);
    set_ir(32'h8003_0004);
    chk("sub_hi_flags", {28'd0, lt, gt, eq, cond_pass}, 32'b0010);
    set_ir(32'h2003_0004);
    chk("sub_cs_flags", {28'd0, lt, gt, eq, cond_pass}, 32'b0011);

    // Store of A to ALUOut; MDR must still hold the last read afterwards
    load_reg(4'd5, 32'hDEAD_BEEF);
    load_reg(4'd6, 32'h0000_0040);
    set_ir(32'hE005_F006);
    cyc('0);
    c = '0; c.alu_src_a = 2'd2; c.alu_op = 3'd5;
    cyc(c);
    c = '0; c.mem_wr = 1; c.i_or_d = 1;
    mem_txn(c, 32'hFFFF_FFFF, 2);
    c = '0; c.reg_write = 1; c.reg_dst = 0; c.mem_to_reg = 2'd2;
    cyc(c);
    c = '0; c.rd1_sel = 1;
    cyc(c);
    c = '0; c.mem_wr = 1;
    mem_txn(c, 32'h0, 0);

    // Randomised mix of datapath cycles and memory transactions
    for (int i = 0; i < 400; i++) begin
      c = rand_ctl();
      if ($urandom_range(0, 9) < 3) begin
        k = int'($urandom_range(1, 3));
        c.mem_rd = k[0]; c.mem_wr = k[1];
        mem_txn(c, $urandom, int'($urandom_range(0, 3)));
      end else begin
        cyc(c);
      end
    end

    // Reset asserted while a read is outstanding
    c = '0; c.mem_rd = 1; c.ir_write = 1;
    t.addr = m_pc; t.we = 0; t.wdata = m_a; t.cycles = 1; t.ir_after = 0;
    exp_q.push_back(t);
    drive(c);
    @(posedge clk);
    model_edge(c);
    @(negedge clk);
    drive('0);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("rst_wait_ctl", {29'd0, mem_req, mem_we, mem_busy}, 32'd0);
    chk("rst_wait_addr", mem_addr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
    drive('0);
    mem_ack = 1;
    mem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    model_edge('0);
    @(negedge clk);
    mem_ack = 0;
    chk("stale_ack_busy", {30'd0, mem_req, mem_busy}, 32'd0);
    chk("stale_ack_ir", instruction, 32'd0);
    set_ir(32'hC000_0000);
    chk("post_rst_fetch_ir", instruction, 32'hC000_0000);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
